// File: rtl/seq_divider_if.sv
// Handshake/data bundle for seq_divider.
//   ena          requester -> divider  level enable/start
//   A, B         requester -> divider  dividend, divisor
//   Q, R         divider -> requester  quotient, remainder (registered)
//   done         divider -> requester  result valid (registered)
//   div_by_zero  divider -> requester  last operation had B==0 (registered)
//   state        divider -> requester  FSM state code for display
interface seq_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ena;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             done;
    logic             div_by_zero;
    logic [3:0]       state;

    modport master (
        output ena, A, B,
        input  Q, R, done, div_by_zero, state
    );

    modport slave (
        input  ena, A, B,
        output Q, R, done, div_by_zero, state
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, priority over everything
//   bus  seq_divider_if slave: ena/A/B in; Q/R/done/div_by_zero/state out
// State codes: IDLE=0, LOAD=1, ITER=2, DONE=3, DIVZ=4; others recover to IDLE.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StLoad = 4'd1,
        StIter = 4'd2,
        StDone = 4'd3,
        StDivz = 4'd4
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             done_q;
    logic             dbz_q;

    // One restoring step: shift the next dividend bit into the partial remainder,
    // subtract the divisor if it fits, and shift the resulting quotient bit into dvd.
    logic [WIDTH:0]   iter_t;
    logic             iter_ge;
    logic [WIDTH:0]   iter_rem;
    logic [WIDTH-1:0] iter_dvd;

    always_comb begin
        iter_t   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        iter_ge  = (iter_t >= {1'b0, dvs_q});
        iter_rem = iter_ge ? (iter_t - {1'b0, dvs_q}) : iter_t;
        iter_dvd = {dvd_q[WIDTH-2:0], iter_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.ena) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    dvd_q <= bus.A;
                    dvs_q <= bus.B;
                    rem_q <= '0;
                    cnt_q <= CntW'(WIDTH);
                    if (bus.B == '0) begin
                        // Divide-by-zero result is published on this same edge.
                        state_q <= StDivz;
                        q_q     <= '1;
                        r_q     <= bus.A;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                    end else begin
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    dvd_q <= iter_dvd;
                    rem_q <= iter_rem;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        // Last step: publish the freshly computed quotient/remainder.
                        state_q <= StDone;
                        q_q     <= iter_dvd;
                        r_q     <= iter_rem[WIDTH-1:0];
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                    end
                end
                StDone, StDivz: begin
                    // A held ena parks here; it must drop before a new run starts.
                    if (!bus.ena) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=4.
module tb_seq_divider;
    localparam int unsigned W = 4;
    localparam int MaxCycles = 20;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run with ena held high and return the number of edges (including
    // the ena-sampling edge) until done. Optionally checks that Q/R hold the
    // previous result until the new one appears.
    task automatic run_div(input int unsigned a, input int unsigned b, input bit chk_hold,
                           input int unsigned prev_q, input int unsigned prev_r,
                           output int lat);
        dif.A   = W'(a);
        dif.B   = W'(b);
        dif.ena = 1'b1;
        lat = 0;
        for (int i = 0; i < MaxCycles; i++) begin
            step();
            lat++;
            if (dif.done) break;
            if (chk_hold) begin
                check("hold_q", dif.Q, prev_q);
                check("hold_r", dif.R, prev_r);
            end
        end
        if (!dif.done) check("run_timeout", 0, 1);
    endtask

    // Drop ena and return to IDLE.
    task automatic finish_run();
        dif.ena = 1'b0;
        step();
        check("exit_state", dif.state, 0);
        check("exit_done", dif.done, 0);
    endtask

    int lat;
    int exp_states[6] = '{1, 2, 2, 2, 2, 3};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        dif.ena  = 1'b0;
        dif.A    = '0;
        dif.B    = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_state", dif.state, 0);
        check("rst_q", dif.Q, 0);
        check("rst_r", dif.R, 0);
        check("rst_done", dif.done, 0);
        check("rst_dbz", dif.div_by_zero, 0);

        // 13 / 4 with a state trace; ena held afterwards keeps it in DONE.
        dif.A   = 4'd13;
        dif.B   = 4'd4;
        dif.ena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("trace_state", dif.state, exp_states[i]);
            check("trace_done", dif.done, (i == 5) ? 1 : 0);
        end
        check("q_13_4", dif.Q, 3);
        check("r_13_4", dif.R, 1);
        check("dbz_13_4", dif.div_by_zero, 0);
        step();
        step();
        check("held_state", dif.state, 3);
        check("held_done", dif.done, 1);
        finish_run();
        check("q_after_exit", dif.Q, 3);

        // 15 / 1, then 3 / 9 with Q/R holding 15/0 until the new result.
        run_div(15, 1, 1'b0, 0, 0, lat);
        check("lat_15_1", lat, 6);
        check("q_15_1", dif.Q, 15);
        check("r_15_1", dif.R, 0);
        finish_run();
        run_div(3, 9, 1'b1, 15, 0, lat);
        check("lat_3_9", lat, 6);
        check("q_3_9", dif.Q, 0);
        check("r_3_9", dif.R, 3);
        finish_run();

        // Divide by zero, then a valid run clears the flag.
        run_div(7, 0, 1'b0, 0, 0, lat);
        check("lat_divz", lat, 2);
        check("divz_state", dif.state, 4);
        check("divz_q", dif.Q, 15);
        check("divz_r", dif.R, 7);
        check("divz_flag", dif.div_by_zero, 1);
        finish_run();
        check("divz_flag_hold", dif.div_by_zero, 1);
        run_div(6, 3, 1'b0, 0, 0, lat);
        check("q_6_3", dif.Q, 2);
        check("r_6_3", dif.R, 0);
        check("dbz_cleared", dif.div_by_zero, 0);
        finish_run();

        // 9 / 2 latched; A/B scrambled during ITER and ena dropped mid-run.
        dif.A   = 4'd9;
        dif.B   = 4'd2;
        dif.ena = 1'b1;
        step();
        check("chg_load", dif.state, 1);
        step();
        check("chg_iter", dif.state, 2);
        lat = 2;
        for (int i = 0; i < MaxCycles; i++) begin
            dif.A = W'(i * 5 + 3);
            dif.B = W'(i + 7);
            if (i == 1) dif.ena = 1'b0;
            step();
            lat++;
            if (dif.done) break;
        end
        check("chg_done", dif.done, 1);
        check("chg_lat", lat, 6);
        check("chg_q", dif.Q, 4);
        check("chg_r", dif.R, 1);
        step();
        check("chg_pulse_done", dif.done, 0);
        check("chg_idle", dif.state, 0);

        // Reset during the second ITER cycle aborts without a result.
        dif.A   = 4'd13;
        dif.B   = 4'd4;
        dif.ena = 1'b1;
        step();
        step();
        step();
        check("abort_pre", dif.state, 2);
        rst     = 1'b1;
        dif.ena = 1'b0;
        step();
        rst = 1'b0;
        check("abort_state", dif.state, 0);
        check("abort_q", dif.Q, 0);
        check("abort_r", dif.R, 0);
        check("abort_done", dif.done, 0);
        check("abort_dbz", dif.div_by_zero, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_result", dif.done, 0);
        end

        // Exhaustive sweep over non-zero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a, b, 1'b0, 0, 0, lat);
                check("sweep_lat", lat, 6);
                check("sweep_q", dif.Q, a / b);
                check("sweep_r", dif.R, a % b);
                check("sweep_recon", dif.Q * b + dif.R, a);
                check("sweep_r_lt_b", (dif.R < b) ? 1 : 0, 1);
                finish_run();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
